// File: rtl/bcd2bin_pkg.sv
// Shared widths, stage weights and the pipeline payload type for the BCD-to-binary converter.
// Shift-add multiply helper keeps every stage free of the `*` operator.
package bcd2bin_pkg;

  localparam int BCD_W  = 17;
  localparam int BIN_W  = 11;
  localparam int ACC_W  = 15;
  localparam int DIG_W  = 4;
  localparam int DIGS_W = 4 * DIG_W;

  localparam logic [BIN_W-1:0] BIN_MAX = 11'd2047;

  localparam int W_Q = 1000;
  localparam int W_B = 100;
  localparam int W_S = 10;
  localparam int W_G = 1;

  // Payload carried between stages; digs holds the not-yet-consumed nibbles, MSB first.
  typedef struct packed {
    logic              vld;
    logic              err;
    logic [ACC_W-1:0]  acc;
    logic [DIGS_W-1:0] digs;
  } stage_t;

  function automatic logic [ACC_W-1:0] shift_mul(input logic [DIG_W-1:0] d,
                                                 input int               weight);
    logic [ACC_W-1:0] x;
    x = ACC_W'(d);
    case (weight)
      W_Q:     return (x << 10) - (x << 4) - (x << 3);
      W_B:     return (x << 6) + (x << 5) + (x << 2);
      W_S:     return (x << 3) + (x << 1);
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/bcd2bin_stage.sv
// One multiply-accumulate stage: adds the leading digit times WEIGHT to acc and
// shifts the consumed digit out of the payload.
module bcd2bin_stage
  import bcd2bin_pkg::*;
#(
  parameter int WEIGHT = W_G
) (
  input  logic   clk,
  input  logic   rst_n,
  input  stage_t in_p,
  output stage_t out_p
);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: data registers are reset along with valid so the reset state is fully defined.
    if (!rst_n) begin
      out_p <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples its predecessor's old value.
      out_p.vld  <= in_p.vld;
      out_p.err  <= in_p.err;
      out_p.acc  <= in_p.acc + shift_mul(in_p.digs[DIGS_W-1 -: DIG_W], WEIGHT);
      out_p.digs <= {in_p.digs[DIGS_W-DIG_W-1:0], {DIG_W{1'b0}}};
    end
  end

endmodule

// File: rtl/bcd2bin.sv
// Five-stage pipelined BCD-to-binary converter (pre, thousands, hundreds, tens, ones + output).
// Range/overflow checking is built only when BCD2BIN_CHECK_EN is defined.
module bcd2bin
  import bcd2bin_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bcd_vld,
  input  logic [BCD_W-1:0] bcd,
  output logic             bin_vld,
  output logic [BIN_W-1:0] bin,
  output logic             bin_err
);

  stage_t p_p, q_p, b_p, s_p, g_p;
  logic   chk_err;

`ifdef BCD2BIN_CHECK_EN
  always_comb begin
    chk_err = bcd[BCD_W-1];
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*DIG_W +: DIG_W] > 4'd9) chk_err = 1'b1;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

  // Pre stage: register the word and start from an empty accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_p <= '0;
    end else begin
      p_p.vld  <= bcd_vld;
      p_p.err  <= chk_err;
      p_p.acc  <= '0;
      p_p.digs <= bcd[DIGS_W-1:0];
    end
  end

  bcd2bin_stage #(.WEIGHT(W_Q)) u_stage_q (.clk(clk), .rst_n(rst_n), .in_p(p_p), .out_p(q_p));
  bcd2bin_stage #(.WEIGHT(W_B)) u_stage_b (.clk(clk), .rst_n(rst_n), .in_p(q_p), .out_p(b_p));
  bcd2bin_stage #(.WEIGHT(W_S)) u_stage_s (.clk(clk), .rst_n(rst_n), .in_p(b_p), .out_p(s_p));
  bcd2bin_stage #(.WEIGHT(W_G)) u_stage_g (.clk(clk), .rst_n(rst_n), .in_p(s_p), .out_p(g_p));

  // Output register; bin is zeroed on bubbles so consumers never see stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_vld <= 1'b0;
      bin     <= '0;
    end else begin
      bin_vld <= g_p.vld;
      bin     <= g_p.vld ? g_p.acc[BIN_W-1:0] : '0;
    end
  end

`ifdef BCD2BIN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_err <= 1'b0;
    end else begin
      bin_err <= g_p.vld & (g_p.err | (g_p.acc > ACC_W'(BIN_MAX)));
    end
  end

  logic unused_digs;
  assign unused_digs = ^g_p.digs;
`else
  assign bin_err = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{bcd[BCD_W-1], g_p.err, g_p.acc[ACC_W-1:BIN_W], g_p.digs};
`endif

endmodule

// File: tb/tb_bcd2bin.sv
// Self-checking bench for bcd2bin: directed cases plus random words against a
// cycle-indexed arithmetic reference model with a fixed 5-cycle latency.
module tb_bcd2bin;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bcd_vld;
  logic [16:0] bcd;
  logic        bin_vld;
  logic [10:0] bin;
  logic        bin_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        vld;
    logic [10:0] bin;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  bcd2bin dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bcd_vld(bcd_vld),
    .bcd    (bcd),
    .bin_vld(bin_vld),
    .bin    (bin),
    .bin_err(bin_err)
  );

  always #5 clk = ~clk;

  // Reference: decimal weighting with plain arithmetic, result modulo 2048.
  function automatic exp_t model(input logic v, input logic [16:0] d);
    exp_t e;
    int   th, hu, te, on, total;
    logic bad;
    th    = int'(d[15:12]);
    hu    = int'(d[11:8]);
    te    = int'(d[7:4]);
    on    = int'(d[3:0]);
    total = th * 1000 + hu * 100 + te * 10 + on;
    bad   = d[16] || th > 9 || hu > 9 || te > 9 || on > 9 || total > 2047;
    e.vld = v;
    e.bin = v ? 11'(total % 2048) : 11'd0;
`ifdef BCD2BIN_CHECK_EN
    e.err = v && bad;
`else
    e.err = 1'b0;
    if (bad) e.err = 1'b0;
`endif
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    check("bin_vld", {31'd0, bin_vld}, {31'd0, e.vld});
    check("bin",     {21'd0, bin},     {21'd0, e.bin});
    check("bin_err", {31'd0, bin_err}, {31'd0, e.err});
  endtask

  // One clock: drive at negedge, sample 1ns after posedge against the word from 5 clocks ago.
  task automatic step(input logic v, input logic [16:0] d);
    exp_t e;
    @(negedge clk);
    bcd_vld = v;
    bcd     = d;
    exp_q.push_back(model(v, d));
    @(posedge clk);
    #1;
    if (exp_q.size() > 5) begin
      e = exp_q.pop_front();
    end else begin
      e = '{vld: 1'b0, bin: 11'd0, err: 1'b0};
    end
    check_outputs(e);
  endtask

  initial begin
    exp_t idle;
    logic [16:0] r;
    idle    = '{vld: 1'b0, bin: 11'd0, err: 1'b0};
    rst_n   = 1'b0;
    bcd_vld = 1'b0;
    bcd     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs(idle);
    @(negedge clk);
    rst_n = 1'b1;

    // Single max-range word, then idle until it drains.
    step(1'b1, 17'h0_2047);
    repeat (6) step(1'b0, 17'h0);

    // Back-to-back words, then a bubble right after the last.
    step(1'b1, 17'h0_0000);
    step(1'b1, 17'h0_0001);
    step(1'b1, 17'h0_0999);
    step(1'b1, 17'h0_1000);
    repeat (6) step(1'b0, 17'h0);

    // Overflow, non-BCD nibble, reserved bit, all-0xF worst case.
    step(1'b1, 17'h0_2048);
    step(1'b1, 17'h0_00A5);
    step(1'b1, 17'h1_0000);
    step(1'b1, 17'h1_FFFF);
    step(1'b0, 17'h0_1234);
    repeat (6) step(1'b0, 17'h0);

    // Three words in flight, then an asynchronous reset pulse.
    step(1'b1, 17'h0_0123);
    step(1'b1, 17'h0_0456);
    step(1'b1, 17'h0_0789);
    @(negedge clk);
    bcd_vld = 1'b0;
    rst_n   = 1'b0;
    #1;
    check_outputs(idle);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(1'b0, 17'h0);
    step(1'b1, 17'h0_0042);
    repeat (6) step(1'b0, 17'h0);

    // Random mix of legal BCD words, raw 17-bit words and bubbles.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        r = {1'b0, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
             4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end else begin
        r = 17'($urandom);
      end
      step(1'($urandom_range(0, 1)), r);
    end
    repeat (6) step(1'b0, 17'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
